// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane writes, a sequential zero-clear engine and a sticky out-of-range flag.
// Read latency RD_LATENCY (1 or 2), fully pipelined; no backpressure: requests while init_busy is high are dropped.
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  output logic                             init_busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             oor_err
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam bit HAS_OOR = (DEPTH < (2 ** ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc, rd_acc, wr_in, rd_in;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_dat;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return !HAS_OOR || (32'(a) < DEPTH);
  endfunction

  assign init_busy = (state_q == ST_CLEAR);
  assign wr_acc    = wr_en & ~init_busy;
  assign rd_acc    = rd_en & ~init_busy;
  assign wr_in     = addr_ok(wr_addr);
  assign rd_in     = addr_ok(rd_addr);
  assign wr_idx    = wr_addr[IDX_W-1:0];
  assign rd_idx    = rd_addr[IDX_W-1:0];

  // A clear request always restarts the sweep at word 0, even mid-sweep.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_err <= 1'b0;
    end else if (clear) begin
      oor_err <= 1'b0;
    end else if ((wr_acc && !wr_in) || (rd_acc && !rd_in)) begin
      oor_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_addr_q[IDX_W-1:0]] <= '0;
    end else if (wr_acc && wr_in) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first bypass merges only the enabled lanes over the stored word.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[rd_idx];
      if (RDW_MODE == 1 && wr_acc && wr_in && (wr_addr == rd_addr)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) s1_dat <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= s1_vld;
        if (s1_vld) rd_data <= s1_dat;
      end
    end
  end else begin : g_lat1
    assign rd_valid = s1_vld;
    assign rd_data  = s1_dat;
  end
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: three instances (L1/old-data, L2/new-data, DEPTH 12 out-of-range)
// driven from a vector table plus hand sequences for clear, restart and asynchronous reset.
module tb_dual_port_ram_be;
  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        clear     [3];
  logic        init_busy [3];
  logic        wr_en     [3];
  logic [3:0]  wr_addr   [3];
  logic [3:0]  wr_be     [3];
  logic [31:0] wr_data   [3];
  logic        rd_en     [3];
  logic [3:0]  rd_addr   [3];
  logic [31:0] rd_data   [3];
  logic        rd_valid  [3];
  logic        oor_err   [3];

  always #5 clk = ~clk;

  dual_port_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .clear(clear[0]), .init_busy(init_busy[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .oor_err(oor_err[0]));
  dual_port_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .clear(clear[1]), .init_busy(init_busy[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .oor_err(oor_err[1]));
  dual_port_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .clear(clear[2]), .init_busy(init_busy[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_be(wr_be[2]), .wr_data(wr_data[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .oor_err(oor_err[2]));

  typedef struct {
    int          k;
    logic [31:0] dat;
    int          due;
  } exp_t;

  typedef struct {
    int          k;
    bit          we;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          re;
    logic [3:0]  ra;
    logic [31:0] rexp;
    bit          oor;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] last_dat [3];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          idx;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int find(input int k);
    foreach (sb[i]) if (sb[i].k == k) return i;
    return -1;
  endfunction

  task automatic exp_rd(input int k, input logic [31:0] d);
    sb.push_back('{k, d, cyc + lat_of(k)});
  endtask

  function automatic vec_t v(input int k, input bit we, input logic [3:0] wa, input logic [3:0] be,
                             input logic [31:0] wd, input bit re, input logic [3:0] ra,
                             input logic [31:0] rexp, input bit oor);
    vec_t r;
    r = '{k, we, wa, be, wd, re, ra, rexp, oor};
    return r;
  endfunction

  // Scoreboard: each rd_valid pops the oldest expectation of that instance and checks data and arrival cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n[k]) begin
        idx = find(k);
        while (idx >= 0 && sb[idx].due < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_valid[%0d] missing at cycle %0d: got 0 expected 1", k, sb[idx].due);
          sb.delete(idx);
          idx = find(k);
        end
        if (rd_valid[k]) begin
          if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_valid[%0d] unexpected at cycle %0d: got 1 expected 0", k, cyc);
          end else begin
            check($sformatf("rd_cycle[%0d]", k), cyc, sb[idx].due);
            check($sformatf("rd_data[%0d]", k), rd_data[k], sb[idx].dat);
            sb.delete(idx);
          end
          last_dat[k] = rd_data[k];
        end else begin
          check($sformatf("rd_hold[%0d]", k), rd_data[k], last_dat[k]);
        end
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      clear[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0; wr_be[k] = '0;
    end
  endtask

  // Counts cycles with init_busy high; optionally re-pulses clear or attempts an access mid-sweep.
  task automatic count_busy(input int k, input int restart_at, input int poke_at, output int n);
    n = 0;
    while (init_busy[k] && n < 200) begin
      n++;
      clear[k] = (n == restart_at);
      if (n == poke_at) begin
        wr_en[k] = 1'b1; wr_addr[k] = 4'd1; wr_be[k] = 4'hF; wr_data[k] = 32'hFFFF_FFFF;
        rd_en[k] = 1'b1; rd_addr[k] = 4'd1;
      end else begin
        wr_en[k] = 1'b0; rd_en[k] = 1'b0;
      end
      @(negedge clk);
    end
    clear[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    int   k, n0, n1, n2;

    tbl.push_back(v(0, 0, 0, 4'h0, 32'h0,         1, 5, 32'h0000_0000, 0));
    tbl.push_back(v(0, 1, 3, 4'hF, 32'hAABB_CCDD, 0, 0, 32'h0,         0));
    tbl.push_back(v(0, 1, 3, 4'h5, 32'h1122_3344, 0, 0, 32'h0,         0));
    tbl.push_back(v(0, 0, 0, 4'h0, 32'h0,         1, 3, 32'hAA22_CC44, 0));
    tbl.push_back(v(0, 1, 7, 4'hF, 32'h0000_0001, 0, 0, 32'h0,         0));
    tbl.push_back(v(0, 1, 7, 4'hF, 32'hFFFF_FFFF, 1, 7, 32'h0000_0001, 0));
    tbl.push_back(v(0, 0, 0, 4'h0, 32'h0,         1, 7, 32'hFFFF_FFFF, 0));
    tbl.push_back(v(0, 1, 9, 4'hF, 32'h1234_5678, 1, 8, 32'h0000_0000, 0));
    tbl.push_back(v(0, 1, 9, 4'h0, 32'hFFFF_FFFF, 1, 9, 32'h1234_5678, 0));
    tbl.push_back(v(0, 0, 0, 4'h0, 32'h0,         1, 9, 32'h1234_5678, 0));
    tbl.push_back(v(1, 1, 7, 4'hF, 32'h0000_0001, 0, 0, 32'h0,         0));
    tbl.push_back(v(1, 1, 7, 4'hF, 32'hFFFF_FFFF, 1, 7, 32'hFFFF_FFFF, 0));
    tbl.push_back(v(1, 1, 7, 4'h3, 32'h0000_0000, 1, 7, 32'hFFFF_0000, 0));
    tbl.push_back(v(1, 0, 0, 4'h0, 32'h0,         1, 7, 32'hFFFF_0000, 0));
    tbl.push_back(v(1, 1, 0, 4'hF, 32'd10,        0, 0, 32'h0,         0));
    tbl.push_back(v(1, 1, 1, 4'hF, 32'd11,        0, 0, 32'h0,         0));
    tbl.push_back(v(1, 1, 2, 4'hF, 32'd12,        0, 0, 32'h0,         0));
    tbl.push_back(v(1, 1, 5, 4'hF, 32'h55,        1, 0, 32'd10,        0));
    tbl.push_back(v(1, 0, 0, 4'h0, 32'h0,         1, 1, 32'd11,        0));
    tbl.push_back(v(1, 0, 0, 4'h0, 32'h0,         1, 2, 32'd12,        0));
    tbl.push_back(v(2, 1, 4, 4'hF, 32'hCAFE_F00D, 0, 0, 32'h0,         0));
    tbl.push_back(v(2, 1, 11, 4'hF, 32'h0BAD_BEEF, 1, 4, 32'hCAFE_F00D, 0));
    tbl.push_back(v(2, 0, 0, 4'h0, 32'h0,         1, 11, 32'h0BAD_BEEF, 0));
    tbl.push_back(v(2, 1, 13, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0,        1));
    tbl.push_back(v(2, 1, 12, 4'hF, 32'hDEAD_BEEF, 1, 14, 32'h0,       1));
    tbl.push_back(v(2, 0, 0, 4'h0, 32'h0,         1, 12, 32'h0,        1));
    tbl.push_back(v(2, 0, 0, 4'h0, 32'h0,         1, 4, 32'hCAFE_F00D, 1));

    for (int j = 0; j < 3; j++) begin
      rst_n[j] = 1'b1; last_dat[j] = '0;
      wr_addr[j] = '0; wr_data[j] = '0; rd_addr[j] = '0;
    end
    idle_all();
    #1;
    for (int j = 0; j < 3; j++) rst_n[j] = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset init_busy[%0d]", j), init_busy[j], 1);
      check($sformatf("reset rd_valid[%0d]", j), rd_valid[j], 0);
      check($sformatf("reset rd_data[%0d]", j), rd_data[j], 0);
      check($sformatf("reset oor_err[%0d]", j), oor_err[j], 0);
    end
    for (int j = 0; j < 3; j++) rst_n[j] = 1'b1;
    fork
      count_busy(0, 0, 0, n0);
      count_busy(1, 0, 0, n1);
      count_busy(2, 0, 0, n2);
    join
    check("init cycles[0]", n0, 16);
    check("init cycles[1]", n1, 16);
    check("init cycles[2]", n2, 12);

    foreach (tbl[i]) begin
      k = tbl[i].k;
      wr_en[k] = tbl[i].we; wr_addr[k] = tbl[i].wa; wr_be[k] = tbl[i].be; wr_data[k] = tbl[i].wd;
      rd_en[k] = tbl[i].re; rd_addr[k] = tbl[i].ra;
      if (tbl[i].re) exp_rd(k, tbl[i].rexp);
      @(negedge clk);
      wr_en[k] = 1'b0; rd_en[k] = 1'b0;
      check($sformatf("oor_err[%0d] vec%0d", k, i), oor_err[k], tbl[i].oor);
    end
    idle_all();
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges: u0 mid-sweep, u2 with a read result on the outputs and oor_err set.
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    repeat (3) @(negedge clk);
    rd_en[2] = 1'b1; rd_addr[2] = 4'd13;
    @(posedge clk);
    #2;
    rd_en[2] = 1'b0;
    check("pre_rst init_busy[0]", init_busy[0], 1);
    check("pre_rst rd_valid[2]", rd_valid[2], 1);
    check("pre_rst oor_err[2]", oor_err[2], 1);
    rst_n[0] = 1'b0; rst_n[2] = 1'b0; last_dat[0] = '0; last_dat[2] = '0;
    #1;
    check("async init_busy[0]", init_busy[0], 1);
    check("async rd_valid[0]", rd_valid[0], 0);
    check("async rd_data[0]", rd_data[0], 0);
    check("async init_busy[2]", init_busy[2], 1);
    check("async rd_valid[2]", rd_valid[2], 0);
    check("async oor_err[2]", oor_err[2], 0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[2] = 1'b1;
    fork
      count_busy(0, 0, 0, n0);
      count_busy(2, 0, 0, n2);
    join
    check("post_rst cycles[0]", n0, 16);
    check("post_rst cycles[2]", n2, 12);

    // Clear re-pulsed on the 6th busy cycle restarts the sweep: 6 + 16 cycles.
    clear[1] = 1'b1;
    @(negedge clk);
    clear[1] = 1'b0;
    count_busy(1, 6, 0, n1);
    check("restart cycles[1]", n1, 22);

    for (int i = 0; i < 16; i++) begin
      wr_en[0] = 1'b1; wr_addr[0] = 4'(i); wr_be[0] = 4'hF; wr_data[0] = 32'h0101_0101 * (i + 1);
      @(negedge clk);
    end
    wr_en[0] = 1'b0;
    rd_en[2] = 1'b1; rd_addr[2] = 4'd13; exp_rd(2, 32'h0);
    @(negedge clk);
    rd_en[2] = 1'b0;
    check("oor set[2]", oor_err[2], 1);

    // A read accepted in the clear cycle still returns the pre-clear word.
    clear[0] = 1'b1; clear[2] = 1'b1;
    rd_en[0] = 1'b1; rd_addr[0] = 4'd3; exp_rd(0, 32'h0404_0404);
    @(negedge clk);
    clear[0] = 1'b0; clear[2] = 1'b0; rd_en[0] = 1'b0;
    fork
      count_busy(0, 0, 10, n0);
      count_busy(2, 0, 0, n2);
    join
    check("clear cycles[0]", n0, 16);
    check("clear cycles[2]", n2, 12);
    check("oor cleared[2]", oor_err[2], 0);

    for (int i = 0; i < 16; i++) begin
      rd_en[0] = 1'b1; rd_addr[0] = 4'(i); exp_rd(0, 32'h0);
      @(negedge clk);
    end
    rd_en[0] = 1'b0;
    rd_en[1] = 1'b1; rd_addr[1] = 4'd7; exp_rd(1, 32'h0);
    rd_en[2] = 1'b1; rd_addr[2] = 4'd4; exp_rd(2, 32'h0);
    @(negedge clk);
    idle_all();
    repeat (4) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Next-generation simple dual-port RAM: one write port and one read port, usable in the same cycle, on a single clock. It adds byte-lane write enables, a selectable read latency of 1 or 2, a selectable read-during-write collision mode, and an out-of-range address flag. Memory is zeroed by a sequential clear engine rather than a single-cycle reset loop. It is the general storage primitive for FIFOs, packet buffers and lookup tables.

Parameters:
DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of one write-enable lane.
DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
ADDR_WIDTH, 8, address width.
RD_LATENCY, 1, read latency; 1 = memory register only, 2 = memory register plus output register.
RDW_MODE, 0, same-address read-during-write behaviour; 0 = old data, 1 = new data (write-first bypass).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; asynchronous, active-low.
clear  in  1  single-cycle request to zero the whole memory.
init_busy  out  1  high while the clear engine runs; ports are blocked.
wr_en  in  1  write request.
wr_addr  in  ADDR_WIDTH  write address.
wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read request.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data carries the result of an accepted read this cycle.
oor_err  out  1  sticky: an out-of-range address was presented on an accepted access.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM enters CLEAR with clr_addr = 0.
  - init_busy = 1; rd_data = 0; rd_valid = 0; oor_err = 0; read pipeline valid bits = 0.
  - Memory array is not reset asynchronously.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes mem[clr_addr] = 0 and increments clr_addr. The cycle that writes DEPTH-1 moves the FSM to IDLE.
  - init_busy is low from the next cycle. After rst_n release, init_busy is high for exactly DEPTH cycles.
  - IDLE: clear = 1 moves to CLEAR next cycle, with clr_addr = 0 and oor_err cleared.
  - clear asserted during CLEAR restarts clr_addr at 0.
- Acceptance:
  - A write is accepted when wr_en & !init_busy; a read when rd_en & !init_busy.
  - Requests made while init_busy = 1 are dropped silently: no memory change, no rd_valid.
- Write:
  - Only lanes with wr_be[i] = 1 are updated.
  - wr_be = 0 with wr_en = 1 is a no-op (still range-checked).
- Read latency:
  - RD_LATENCY = 1: read accepted at cycle N gives rd_data/rd_valid at cycle N+1.
  - RD_LATENCY = 2: result at cycle N+2.
  - One read per cycle, fully pipelined.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its last value when rd_valid = 0.
- Reads in flight when a clear starts still complete with the data sampled at acceptance.
- Collision (accepted write and read in the same cycle, wr_addr == rd_addr):
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the merged word (enabled lanes from wr_data, others old).
  - Different addresses never interact.
- Out of range (addr >= DEPTH, only when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read returns 0 with normal rd_valid timing.
  - Either case sets oor_err on the next edge; it stays set until reset or a clear.
- Clear engine writes take priority; user ports are blocked, so no conflict is possible.

Test Plan:
- Reset/init: DEPTH=16. Release rst_n -> init_busy high exactly 16 cycles. Read addr 5 after init -> rd_data = 0, rd_valid pulses 1 cycle later (RD_LATENCY=1).
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101. Read addr 3 -> 0xAA22CC44.
- Collision: addr 7 holds 0x00000001; same-cycle write 0xFFFFFFFF (be=4'hF) and read of addr 7. RDW_MODE=0 -> 0x00000001; RDW_MODE=1 -> 0xFFFFFFFF.
- Latency/pipelining: RD_LATENCY=2. Back-to-back reads of addrs 0,1,2 holding 10,11,12 -> rd_valid high 3 consecutive cycles starting 2 cycles after the first read; data 10,11,12.
- Clear and blocking: fill all 16 words, pulse clear. Write attempted while init_busy=1 -> dropped. After init_busy falls, every address reads 0.
- Out of range and async reset: DEPTH=12, ADDR_WIDTH=4. Write addr 13 -> memory unchanged, oor_err = 1. Read addr 14 -> rd_data = 0, rd_valid = 1. Assert rst_n low mid-clear, between clock edges -> init_busy=1, rd_valid=0 and oor_err=0 immediately, and the clear restarts from addr 0.
